// File: rtl/frame_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : frame_timing_ctrl_if
// Brief  : Control requests in, raster coordinates and timing flags out.
// Rev    : 1.0  initial release
// ============================================================================
interface frame_timing_ctrl_if #(
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800
);
  localparam int V_BITW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int H_BITW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  logic              start;
  logic              stop;
  logic              single_shot;
  logic [V_BITW-1:0] vcnt;
  logic [H_BITW-1:0] hcnt;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
  logic              frame_end;
  logic              busy;
  logic [15:0]       frame_count;

  modport master (
    output start, stop, single_shot,
    input  vcnt, hcnt, de, hsync, vsync, frame_start, frame_end, busy, frame_count
  );

  modport slave (
    input  start, stop, single_shot,
    output vcnt, hcnt, de, hsync, vsync, frame_start, frame_end, busy, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/frame_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : frame_timing_ctrl
// Brief  : Raster counter with sync/active flags and run/stop/single-shot FSM.
// Rev    : 1.0  initial release
// ============================================================================
module frame_timing_ctrl #(
  parameter int FRAME_HEIGHT  = 525,
  parameter int FRAME_WIDTH   = 800,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int IMAGE_WIDTH   = 640,
  parameter int V_SYNC_START  = 490,
  parameter int V_SYNC_LINES  = 2,
  parameter int H_SYNC_START  = 656,
  parameter int H_SYNC_PIXELS = 96
) (
  input  logic               clock,
  input  logic               reset,
  frame_timing_ctrl_if.slave bus
);
  localparam int V_BITW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int H_BITW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  // All position compares are done at 32 bits so IMAGE_* may equal FRAME_*.
  localparam logic [31:0] c_V_LAST = 32'(FRAME_HEIGHT - 1);
  localparam logic [31:0] c_H_LAST = 32'(FRAME_WIDTH - 1);
  localparam logic [31:0] c_IMG_H  = 32'(IMAGE_HEIGHT);
  localparam logic [31:0] c_IMG_W  = 32'(IMAGE_WIDTH);
  localparam logic [31:0] c_VS_BEG = 32'(V_SYNC_START);
  localparam logic [31:0] c_VS_END = 32'(V_SYNC_START + V_SYNC_LINES);
  localparam logic [31:0] c_HS_BEG = 32'(H_SYNC_START);
  localparam logic [31:0] c_HS_END = 32'(H_SYNC_START + H_SYNC_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic              r_shot;
  logic              w_nxt_shot;
  logic [V_BITW-1:0] r_vcnt;
  logic [V_BITW-1:0] w_nxt_v;
  logic [H_BITW-1:0] r_hcnt;
  logic [H_BITW-1:0] w_nxt_h;
  logic [31:0]       w_v32;
  logic [31:0]       w_h32;
  logic              w_at_hend;
  logic              w_at_end;
  logic              w_last;
  logic              w_new_frame;
  logic              w_nxt_busy;

  logic              r_de;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;
  logic              r_frame_end;
  logic              r_busy;
  logic [15:0]       r_frame_count;

  always_comb begin
    w_at_hend   = (32'(r_hcnt) == c_H_LAST);
    w_at_end    = w_at_hend && (32'(r_vcnt) == c_V_LAST);
    // The running frame is the final one if a stop is pending, arriving now, or single-shot.
    w_last      = (r_state == S_STOPPING) || r_shot || bus.stop;
    w_nxt_state = r_state;
    w_nxt_shot  = r_shot;
    w_nxt_v     = '0;
    w_nxt_h     = '0;
    w_new_frame = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nxt_state = S_RUN;
          w_nxt_shot  = bus.single_shot;
          w_new_frame = 1'b1;
        end
      end
      default: begin
        if ((r_state == S_RUN) && bus.stop) begin
          w_nxt_state = S_STOPPING;
        end
        if (w_at_end) begin
          if (w_last) begin
            w_nxt_state = S_IDLE;
            w_nxt_shot  = 1'b0;
          end else begin
            w_new_frame = 1'b1;
          end
        end else if (w_at_hend) begin
          w_nxt_v = r_vcnt + V_BITW'(1);
        end else begin
          w_nxt_v = r_vcnt;
          w_nxt_h = r_hcnt + H_BITW'(1);
        end
      end
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE);
    w_v32      = 32'(w_nxt_v);
    w_h32      = 32'(w_nxt_h);
  end

  // Flags are derived from the next counter values so they line up with vcnt/hcnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shot        <= 1'b0;
      r_vcnt        <= '0;
      r_hcnt        <= '0;
      r_de          <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state       <= w_nxt_state;
      r_shot        <= w_nxt_shot;
      r_vcnt        <= w_nxt_v;
      r_hcnt        <= w_nxt_h;
      r_de          <= w_nxt_busy && (w_v32 < c_IMG_H) && (w_h32 < c_IMG_W);
      r_hsync       <= w_nxt_busy && (w_h32 >= c_HS_BEG) && (w_h32 < c_HS_END);
      r_vsync       <= w_nxt_busy && (w_v32 >= c_VS_BEG) && (w_v32 < c_VS_END);
      r_frame_start <= w_new_frame;
      r_frame_end   <= w_nxt_busy && (w_v32 == c_V_LAST) && (w_h32 == c_H_LAST);
      r_busy        <= w_nxt_busy;
      if (w_new_frame) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.vcnt        = r_vcnt;
  assign bus.hcnt        = r_hcnt;
  assign bus.de          = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_end   = r_frame_end;
  assign bus.busy        = r_busy;
  assign bus.frame_count = r_frame_count;
endmodule
`default_nettype wire

// File: tb/tb_frame_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_timing_ctrl
// Brief  : Self-checking bench: vector table, directed corners, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_frame_timing_ctrl;
  localparam int FH = 4, FW = 6, IH = 3, IW = 4, HSS = 4, HSP = 1, VSS = 3, VSL = 1;
  localparam int NPOS = FH * FW;

  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  bit   b_done = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  frame_timing_ctrl_if #(.FRAME_HEIGHT(FH), .FRAME_WIDTH(FW)) bus_a ();
  frame_timing_ctrl_if #(.FRAME_HEIGHT(1), .FRAME_WIDTH(1)) bus_b ();

  frame_timing_ctrl #(
    .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
    .V_SYNC_START(VSS), .V_SYNC_LINES(VSL), .H_SYNC_START(HSS), .H_SYNC_PIXELS(HSP)
  ) dut_a (.clock(clock), .reset(rst_a), .bus(bus_a.slave));

  // Degenerate 1x1 raster: one frame per cycle, used to reach the counter wrap quickly.
  frame_timing_ctrl #(
    .FRAME_HEIGHT(1), .FRAME_WIDTH(1), .IMAGE_HEIGHT(1), .IMAGE_WIDTH(1),
    .V_SYNC_START(0), .V_SYNC_LINES(1), .H_SYNC_START(0), .H_SYNC_PIXELS(1)
  ) dut_b (.clock(clock), .reset(rst_b), .bus(bus_b.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int v, input int h, input bit de, input bit hs,
                                       input bit vs, input bit fs, input bit fe,
                                       input bit busy, input int fc);
    return {5'b0, 2'(v), 3'(h), de, hs, vs, fs, fe, busy, 16'(fc)};
  endfunction

  function automatic logic [31:0] snap_a();
    return {5'b0, bus_a.vcnt, bus_a.hcnt, bus_a.de, bus_a.hsync, bus_a.vsync,
            bus_a.frame_start, bus_a.frame_end, bus_a.busy, bus_a.frame_count};
  endfunction

  function automatic logic [31:0] snap_b();
    return {8'b0, bus_b.vcnt, bus_b.hcnt, bus_b.de, bus_b.hsync, bus_b.vsync,
            bus_b.frame_start, bus_b.frame_end, bus_b.busy, bus_b.frame_count};
  endfunction

  // Reference model: running flag, last-frame flag and linear position in the frame.
  bit m_run, m_last, m_fs;
  int m_pos, m_fc;

  task automatic model_reset();
    m_run = 0; m_last = 0; m_fs = 0; m_pos = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit ss);
    m_fs = 0;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_last = ss; m_pos = 0; m_fs = 1; m_fc = (m_fc + 1) % 65536;
      end
    end else begin
      if (sp) m_last = 1;
      if (m_pos == NPOS - 1) begin
        m_pos = 0;
        if (m_last) begin
          m_run = 0; m_last = 0;
        end else begin
          m_fs = 1; m_fc = (m_fc + 1) % 65536;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [31:0] model_exp();
    int v, h;
    v = m_run ? m_pos / FW : 0;
    h = m_run ? m_pos % FW : 0;
    return pack(v, h, m_run && v < IH && h < IW, m_run && h >= HSS && h < HSS + HSP,
                m_run && v >= VSS && v < VSS + VSL, m_fs, m_run && m_pos == NPOS - 1,
                m_run, m_fc);
  endfunction

  task automatic cyc(input bit st, input bit sp, input bit ss);
    bus_a.start = st; bus_a.stop = sp; bus_a.single_shot = ss;
    @(posedge clock);
    model_step(st, sp, ss);
    #1;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.single_shot = 1'b0;
    chk("model", snap_a(), model_exp());
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", snap_a(), 32'h0);
    rst_a = 1'b0;
  endtask

  typedef struct {
    bit          st;
    bit          sp;
    bit          ss;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [25];

  initial begin
    int p, v, h, busy_n, fe_n;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.single_shot = 1'b0;
    for (int i = 0; i < 25; i++) begin
      p = i % NPOS; v = p / FW; h = p % FW;
      tbl[i].st  = (i == 0);
      tbl[i].sp  = 1'b0;
      tbl[i].ss  = 1'b0;
      tbl[i].exp = pack(v, h, v < 3 && h < 4, h == 4, v == 3, p == 0, p == 23, 1, 1 + i / NPOS);
    end

    reset_a();
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].ss);
      chk($sformatf("vec%0d", i), snap_a(), tbl[i].exp);
    end
    repeat (24) cyc(0, 0, 0);
    chk("third_frame_start", snap_a(), pack(0, 0, 1, 0, 0, 1, 0, 1, 3));

    // Stop requested at (1,2) of frame 2.
    reset_a();
    cyc(1, 0, 0);
    repeat (32) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (14) cyc(0, 0, 0);
    chk("stop_last_fe", snap_a(), pack(3, 5, 0, 0, 1, 0, 1, 1, 2));
    cyc(0, 0, 0);
    chk("stopped", snap_a(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2));
    repeat (30) cyc(0, 1, 0);
    chk("stay_idle", snap_a(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2));

    // Single shot with a start mid-frame that must be ignored.
    cyc(1, 0, 1);
    busy_n = bus_a.busy ? 1 : 0;
    fe_n = 0;
    for (int i = 1; i < 40; i++) begin
      cyc(i == 10, 0, 0);
      busy_n += bus_a.busy ? 1 : 0;
      fe_n += bus_a.frame_end ? 1 : 0;
    end
    chk("shot_busy_cycles", 32'(busy_n), 32'd24);
    chk("shot_frame_ends", 32'(fe_n), 32'd1);
    chk("shot_count", 32'(bus_a.frame_count), 32'd3);

    // start+stop together in IDLE, stop on frame_end, start on return to IDLE.
    cyc(1, 1, 0);
    repeat (30) cyc(0, 0, 0);
    chk("start_stop_runs", snap_a(), pack(1, 0, 1, 0, 0, 0, 0, 1, 5));
    repeat (17) cyc(0, 0, 0);
    chk("pre_stop_fe", snap_a(), pack(3, 5, 0, 0, 1, 0, 1, 1, 5));
    cyc(0, 1, 0);
    chk("stop_on_fe", snap_a(), pack(0, 0, 0, 0, 0, 0, 0, 0, 5));
    cyc(1, 0, 0);
    chk("back_to_back", snap_a(), pack(0, 0, 1, 0, 0, 1, 0, 1, 6));

    // Asynchronous reset at (2,3).
    repeat (15) cyc(0, 0, 0);
    chk("at_2_3", snap_a(), pack(2, 3, 1, 0, 0, 0, 0, 1, 6));
    #3;
    rst_a = 1'b1;
    #1;
    chk("async_reset", snap_a(), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    rst_a = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0);
    end

    for (int k = 0; k < 80000 && !b_done; k++) @(posedge clock);
    chk("wrap_done", 32'(b_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.single_shot = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    @(posedge clock);
    #1;
    bus_b.start = 1'b0;
    chk("b_first", snap_b(), 32'h003F_0001);
    repeat (65534) @(posedge clock);
    #1;
    chk("b_ffff", snap_b(), 32'h003F_FFFF);
    @(posedge clock);
    #1;
    chk("b_wrap", snap_b(), 32'h003F_0000);
    bus_b.stop = 1'b1;
    @(posedge clock);
    #1;
    bus_b.stop = 1'b0;
    chk("b_stop", snap_b(), 32'h0000_0000);
    b_done = 1'b1;
  end
endmodule
`default_nettype wire

// File: doc/frame_timing_ctrl.md
Name: frame_timing_ctrl

Overview:
- Generates the raster coordinate sequence (vcnt/hcnt) plus sync and active-area flags that drive the image processor pipeline and its coordinate adjusters.
- Provides a start/stop/single-shot control FSM so software or upstream logic can run frames continuously, run exactly one frame, or halt cleanly at a frame boundary.
- Sits at the head of the image_processor datapath; all downstream counters derive from its outputs.

Parameters:
- FRAME_HEIGHT, 525, total lines per frame including sync/blanking.
- FRAME_WIDTH, 800, total pixels per line including sync/blanking.
- IMAGE_HEIGHT, 480, active lines, rows 0..IMAGE_HEIGHT-1; must be <= FRAME_HEIGHT.
- IMAGE_WIDTH, 640, active pixels, columns 0..IMAGE_WIDTH-1; must be <= FRAME_WIDTH.
- V_SYNC_START, 490, first line on which vsync is asserted.
- V_SYNC_LINES, 2, vsync width in lines; V_SYNC_START+V_SYNC_LINES <= FRAME_HEIGHT.
- H_SYNC_START, 656, first pixel on which hsync is asserted.
- H_SYNC_PIXELS, 96, hsync width in pixels; H_SYNC_START+H_SYNC_PIXELS <= FRAME_WIDTH.
- Derived: V_BITW = $clog2(FRAME_HEIGHT), H_BITW = $clog2(FRAME_WIDTH).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin running.
- stop  in  1  single-cycle request to halt at the end of the current frame.
- single_shot  in  1  sampled with an accepted start; 1 = run exactly one frame.
- vcnt  out  V_BITW  current line.
- hcnt  out  H_BITW  current pixel.
- de  out  1  high when vcnt < IMAGE_HEIGHT and hcnt < IMAGE_WIDTH.
- hsync  out  1  high when H_SYNC_START <= hcnt < H_SYNC_START+H_SYNC_PIXELS.
- vsync  out  1  high when V_SYNC_START <= vcnt < V_SYNC_START+V_SYNC_LINES.
- frame_start  out  1  one-cycle pulse on the cycle with vcnt=0, hcnt=0 while running.
- frame_end  out  1  one-cycle pulse on the cycle with vcnt=FRAME_HEIGHT-1, hcnt=FRAME_WIDTH-1 while running.
- busy  out  1  high in RUN or STOPPING.
- frame_count  out  16  number of frames started since reset; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE; vcnt=0, hcnt=0; de, hsync, vsync, frame_start, frame_end, busy = 0; frame_count=0; stop latch and single-shot latch cleared.
- Registered outputs: de/hsync/vsync/frame_start/frame_end are computed from next-state counters, so they align with vcnt/hcnt in the same cycle. There is no extra latency.
- FSM states:
  - IDLE: counters held at 0, all flags 0. When start=1, the next cycle enters RUN with vcnt=0, hcnt=0, frame_start=1, frame_count+1. single_shot is latched at that edge.
  - RUN: each cycle hcnt increments. At FRAME_WIDTH-1, hcnt wraps to 0 and vcnt increments. At (FRAME_HEIGHT-1, FRAME_WIDTH-1), both wrap to 0 and the next frame begins: frame_start=1, frame_count+1. stop=1 moves the FSM to STOPPING; counting continues unchanged.
  - STOPPING: counting continues. On the cycle after frame_end, the FSM goes to IDLE, counters return to 0, and no frame_start is issued.
- Single-shot: the single-shot latch makes RUN behave as STOPPING from the first cycle. Exactly one frame is produced, then IDLE.
- start while busy: ignored; single_shot is not re-sampled.
- stop in IDLE: ignored.
- start and stop in the same cycle in IDLE: start is accepted and stop is ignored, so the block runs continuously.
- stop in STOPPING: no effect.
- stop coinciding with frame_end in RUN: the current frame is the last; IDLE follows on the next cycle.
- Back-to-back: start asserted on the same cycle the FSM returns to IDLE is accepted. RUN then begins one cycle later, giving exactly one idle cycle between frames.
- Reset mid-frame: immediate return to reset values; no frame_end is emitted.
- frame_count 0xFFFF + 1 = 0x0000.

Test Plan:
- Params FRAME 4x6, IMAGE 3x4, HSYNC 4/1, VSYNC 3/1. Reset, then start pulse -> next cycle vcnt=0, hcnt=0, frame_start=1, busy=1, frame_count=1. hcnt runs 0..5 then vcnt increments; de=1 only for v<3, h<4; hsync only at h=4; vsync only on v=3.
- Continuous run for 3 frames -> frame_start every 24 cycles, frame_end at (3,5) each frame, frame_count=3, busy stays 1.
- stop pulse at (1,2) of frame 2 -> frame 2 completes, frame_end at (3,5), next cycle busy=0, vcnt=hcnt=0, no further frame_start, frame_count=2.
- start with single_shot=1 -> exactly 24 active cycles and one frame_end, then IDLE. A start issued during the frame is ignored.
- start+stop same cycle in IDLE -> runs continuously. stop exactly on frame_end -> IDLE on the next cycle. start on the return-to-IDLE cycle -> new frame_start 2 cycles after frame_end.
- Reset asserted mid-frame at (2,3) -> all outputs 0 immediately (asynchronous), frame_count=0. Separately, force 65536 frame starts -> frame_count wraps to 0.
